pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Instruction-fetch controller for the 31-instruction MIPS core. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and registers each fetched instruction for decode. Sits directly upstream of the sequential-PC adder: `pc_o` drives the adder's `a` input, with `b` tied to 32'd4, and the adder's sum returns as `seq_pc_i`. Branch and jump targets from execute arrive on the redirect port.

## Interface
Parameters:
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.

Ports (one clock `clk`; reset `rst_n` is synchronous and active-low):
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous active-low reset.
- `pc_o` out 32: current PC; feeds the adder's `a` input.
- `seq_pc_i` in 32: adder sum, equal to `pc_o` + 4.
- `redirect_valid` in 1: taken branch or jump this cycle.
- `redirect_pc` in 32: target; bits [1:0] ignored and forced to 0.
- `stall` in 1: decode cannot accept the held instruction.
- `imem_req` out 1: read request.
- `imem_addr` out 32: read word address.
- `imem_ack` in 1: read data valid this cycle.
- `imem_rdata` in 32: instruction word.
- `if_valid` out 1: `if_instr`/`if_pc` hold a valid instruction.
- `if_instr` out 32: fetched instruction.
- `if_pc` out 32: address of `if_instr`.

## Operation
- Registers:
  - `pc`: drives `pc_o`.
  - `pending_pc`: redirect target latched during FLUSH.
  - `state`.
  - `if_valid`, `if_instr`, `if_pc`.
- `imem_req` = (state ∈ {REQ, FLUSH}).
- `imem_addr` = `pc` in REQ and FLUSH. Address and request stay stable until `imem_ack`.
- States:
  - IDLE: entered on reset. Next cycle goes to REQ, unconditionally.
  - REQ:
    - `imem_ack` with no redirect: `if_instr` <= `imem_rdata`, `if_pc` <= `pc`, `if_valid` <= 1, `pc` <= `seq_pc_i`, go to HOLD.
    - `imem_ack` with `redirect_valid`: discard the data, `pc` <= `redirect_pc`, stay in REQ.
    - `redirect_valid` with no ack: `pending_pc` <= `redirect_pc`, go to FLUSH.
  - FLUSH (a request is outstanding, but its result is dead):
    - `redirect_valid` overwrites `pending_pc`; the latest redirect wins.
    - On `imem_ack`: discard the data. `pc` <= `redirect_pc` if a redirect arrives in the same cycle, else `pending_pc`. Go to REQ.
  - HOLD:
    - `redirect_valid` (has priority over `stall`): `if_valid` <= 0, `pc` <= `redirect_pc`, go to REQ.
    - Otherwise `stall`=1: hold everything.
    - Otherwise `stall`=0: instruction consumed, `if_valid` <= 0, go to REQ.
- A redirect never lets a stale instruction reach decode with `if_valid`=1.
- `if_valid` is 0 in REQ, FLUSH and IDLE. In REQ or FLUSH, `redirect_valid` leaves `if_valid`, `if_instr` and `if_pc` unchanged.
- PC arithmetic is 32-bit wrap. 32'hFFFF_FFFC + 4 → 0 comes from the adder; no special handling is needed here.
- `stall` is ignored outside HOLD.

## Timing
- Reset values (`rst_n`=0 at a clock edge):
  - state = IDLE, `pc_o` = `RESET_PC`, `pending_pc` = 0.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0.
- Reset mid-request abandons the request. The memory must tolerate `imem_req` dropping without an ack.
- First request: `imem_req` goes to 1 in the second cycle after `rst_n` rises.
- `imem_ack` is sampled in the same cycle as `imem_req`. A zero-wait memory may return ack in the first REQ cycle.
- Latency: ack in cycle N → `if_valid`=1 in cycle N+1.
- Peak throughput is one instruction per 2 cycles (REQ, HOLD alternate); this is sufficient for the multi-cycle core.
- Redirect takes effect on the next edge. The new address appears on `imem_addr` one cycle later, or after the outstanding ack when in FLUSH.

## Structure
- Shared package `mips_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, HOLD, FLUSH}.
  - `RESET_PC_DEFAULT`.
  - `INSTR_W` = 32.
- Single flat module; no sub-module.
- The adder stays external and is instantiated by the fetch stage wrapper.

## Test plan
- Reset then zero-wait memory (ack whenever req) → `imem_addr` sequence 0x00400000, 0x00400004, 0x00400008. `if_valid` pulses every other cycle; `if_pc` matches the address one cycle later.
- `stall` held 3 cycles in HOLD with `if_instr`=0x8C080000 → `if_valid`, `if_instr` and `if_pc` stable; `imem_req`=0; resumes after `stall` drops.
- Redirect to 0x00400100 in REQ, ack delayed 3 cycles → state goes to FLUSH. The ack's data is dropped with `if_valid` remaining 0. The next `imem_addr` is 0x00400100.
- Two redirects in FLUSH (0x200, then 0x300 latched into `pending_pc`), and the cycle of the outstanding ack carries no redirect → fetch resumes at 0x00000300. Separately, a redirect to 0x400 in the same cycle as that ack → fetch resumes at 0x00000400.
- Redirect 0x00400023 in HOLD with `stall`=1 → `if_valid` drops next cycle; next `imem_addr` is 0x00400020.
- Assert `rst_n`=0 during FLUSH → next cycle state IDLE, `pc_o`=0x00400000, `imem_req`=0, `if_valid`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end.
// Holds the fetch FSM state encoding and the fetch width and reset constants.
package mips_pkg;

    localparam int          INSTR_W          = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, runs the imem req/ack handshake
// and registers one fetched instruction at a time for decode.
module pc_fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [31:0]         pc_o,
    input  logic [31:0]         seq_pc_i,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                if_valid,
    output logic [INSTR_W-1:0]  if_instr,
    output logic [31:0]         if_pc
);

    fetch_state_t       state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        pending_pc_q, pending_pc_d;
    logic               if_valid_q, if_valid_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        redir_pc;

    assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        pc_d = redir_pc;
                    end else begin
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                        pc_d       = seq_pc_i;
                        state_d    = HOLD;
                    end
                end else if (redirect_valid) begin
                    pending_pc_d = redir_pc;
                    state_d      = FLUSH;
                end
            end
            // The outstanding read is dead; wait for its ack before re-issuing.
            FLUSH: begin
                if (redirect_valid) pending_pc_d = redir_pc;
                if (imem_ack) begin
                    pc_d    = redirect_valid ? redir_pc : pending_pc_q;
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pc_d       = redir_pc;
                    state_d    = REQ;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    state_d    = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pending_pc_q <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign imem_req  = (state_q == REQ) || (state_q == FLUSH);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;

endmodule
